// File: rtl/branch_predictor_table_if.sv
// Predictor bus: fetch-side request/response, execute-side update, statistics.
// Handshake: req_valid and upd_valid are single-cycle strobes with no ready;
// the predictor accepts every strobe on the rising edge where it is high.
// pred_valid is high for exactly one cycle after each accepted request.
interface branch_predictor_table_if #(
    parameter int INDEX_BITS = 6
);
    logic                  req_valid;
    logic [31:0]           req_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_index;
    logic                  upd_valid;
    logic [INDEX_BITS-1:0] upd_index;
    logic                  upd_taken;
    logic                  upd_pred;
    logic [15:0]           stat_updates;
    logic [15:0]           stat_mispredicts;

    // Fetch/execute side
    modport master (
        output req_valid, req_pc, upd_valid, upd_index, upd_taken, upd_pred,
        input  pred_valid, pred_taken, pred_index, stat_updates, stat_mispredicts
    );

    // Predictor side
    modport slave (
        input  req_valid, req_pc, upd_valid, upd_index, upd_taken, upd_pred,
        output pred_valid, pred_taken, pred_index, stat_updates, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Bimodal / gshare branch direction predictor built from a flop table of
// saturating counters. Predictions read the table before any same-edge
// update (no bypass); the global history advances only on resolved updates.
// HIST_BITS must be between 2 and INDEX_BITS.
module branch_predictor_table #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 6,
    parameter int MODE       = 0,
    parameter int PC_LSB     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_predictor_table_if.slave  bus
);
    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    logic [CTR_BITS-1:0]   r_table [DEPTH];
    logic [HIST_BITS-1:0]  r_ghr;
    logic                  r_pred_valid;
    logic                  r_pred_taken;
    logic [INDEX_BITS-1:0] r_pred_index;
    logic [15:0]           r_stat_updates;
    logic [15:0]           r_stat_mispredicts;

    logic [INDEX_BITS-1:0] w_base;
    logic [INDEX_BITS-1:0] w_ghr_ext;
    logic [INDEX_BITS-1:0] w_idx;

    // Request index: PC slice, optionally hashed with the zero-extended history
    always_comb begin
        w_base    = bus.req_pc[PC_LSB +: INDEX_BITS];
        w_ghr_ext = '0;
        w_ghr_ext[HIST_BITS-1:0] = r_ghr;
        w_idx     = w_base;
        if (MODE == 1) begin
            w_idx = w_base ^ w_ghr_ext;
        end
    end

    // Registered prediction; index and direction hold when no request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_index <= '0;
        end else begin
            r_pred_valid <= bus.req_valid;
            if (bus.req_valid) begin
                r_pred_index <= w_idx;
                r_pred_taken <= r_table[w_idx][CTR_BITS-1];
            end
        end
    end

    // Counter table training with saturation at both ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CTR_INIT;
            end
        end else if (bus.upd_valid) begin
            if (bus.upd_taken) begin
                if (r_table[bus.upd_index] != CTR_MAX) begin
                    r_table[bus.upd_index] <= r_table[bus.upd_index] + CTR_ONE;
                end
            end else begin
                if (r_table[bus.upd_index] != CTR_ZERO) begin
                    r_table[bus.upd_index] <= r_table[bus.upd_index] - CTR_ONE;
                end
            end
        end
    end

    // Non-speculative global history, shifted in on every update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (bus.upd_valid) begin
            r_ghr <= {r_ghr[HIST_BITS-2:0], bus.upd_taken};
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else if (bus.upd_valid) begin
            if (r_stat_updates != 16'hFFFF) begin
                r_stat_updates <= r_stat_updates + 16'd1;
            end
            if ((bus.upd_pred != bus.upd_taken) && (r_stat_mispredicts != 16'hFFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
            end
        end
    end

    assign bus.pred_valid       = r_pred_valid;
    assign bus.pred_taken       = r_pred_taken;
    assign bus.pred_index       = r_pred_index;
    assign bus.stat_updates     = r_stat_updates;
    assign bus.stat_mispredicts = r_stat_mispredicts;
endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench for branch_predictor_table: default bimodal instance,
// a gshare instance and a 3-bit-counter instance share clock and reset.
module tb_branch_predictor_table;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    branch_predictor_table_if #(.INDEX_BITS(6)) d_if ();
    branch_predictor_table_if #(.INDEX_BITS(6)) g_if ();
    branch_predictor_table_if #(.INDEX_BITS(6)) c_if ();

    branch_predictor_table u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (d_if.slave)
    );

    branch_predictor_table #(.MODE(1)) u_gs (
        .clk   (clk),
        .reset (reset),
        .bus   (g_if.slave)
    );

    branch_predictor_table #(.CTR_BITS(3)) u_c3 (
        .clk   (clk),
        .reset (reset),
        .bus   (c_if.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drivers for the default instance
    task automatic d_upd(input logic taken, input logic pred, input int n);
        d_if.upd_valid = 1'b1;
        d_if.upd_index = 6'd4;
        d_if.upd_taken = taken;
        d_if.upd_pred  = pred;
        repeat (n) tick();
        d_if.upd_valid = 1'b0;
    endtask

    task automatic d_req(input string tag, input logic exp_taken);
        d_if.req_valid = 1'b1;
        d_if.req_pc    = 32'h10;
        tick();
        d_if.req_valid = 1'b0;
        check(tag, {31'd0, d_if.pred_taken}, {31'd0, exp_taken});
    endtask

    // Drivers for the gshare instance
    task automatic g_upd(input logic taken, input int n);
        g_if.upd_valid = 1'b1;
        g_if.upd_index = 6'd0;
        g_if.upd_taken = taken;
        g_if.upd_pred  = 1'b0;
        repeat (n) tick();
        g_if.upd_valid = 1'b0;
    endtask

    task automatic g_req(input string tag, input logic [5:0] exp_idx);
        g_if.req_valid = 1'b1;
        g_if.req_pc    = 32'h10;
        tick();
        g_if.req_valid = 1'b0;
        check(tag, {26'd0, g_if.pred_index}, {26'd0, exp_idx});
    endtask

    // Drivers for the 3-bit-counter instance
    task automatic c_req(input string tag, input logic exp_taken);
        c_if.req_valid = 1'b1;
        c_if.req_pc    = 32'h10;
        tick();
        c_if.req_valid = 1'b0;
        check(tag, {31'd0, c_if.pred_taken}, {31'd0, exp_taken});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        d_if.req_valid = 1'b0; d_if.req_pc = '0; d_if.upd_valid = 1'b0;
        d_if.upd_index = '0;   d_if.upd_taken = 1'b0; d_if.upd_pred = 1'b0;
        g_if.req_valid = 1'b0; g_if.req_pc = '0; g_if.upd_valid = 1'b0;
        g_if.upd_index = '0;   g_if.upd_taken = 1'b0; g_if.upd_pred = 1'b0;
        c_if.req_valid = 1'b0; c_if.req_pc = '0; c_if.upd_valid = 1'b0;
        c_if.upd_index = '0;   c_if.upd_taken = 1'b0; c_if.upd_pred = 1'b0;

        // Reset state
        #12;
        check("rst_pred_valid", {31'd0, d_if.pred_valid}, 32'd0);
        check("rst_pred_taken", {31'd0, d_if.pred_taken}, 32'd0);
        check("rst_pred_index", {26'd0, d_if.pred_index}, 32'd0);
        check("rst_stat_upd",   {16'd0, d_if.stat_updates}, 32'd0);
        check("rst_stat_mis",   {16'd0, d_if.stat_mispredicts}, 32'd0);
        reset = 1'b0;

        // First prediction, then idle cycle holds index
        d_if.req_valid = 1'b1;
        d_if.req_pc    = 32'h10;
        tick();
        d_if.req_valid = 1'b0;
        check("first_valid", {31'd0, d_if.pred_valid}, 32'd1);
        check("first_index", {26'd0, d_if.pred_index}, 32'd4);
        check("first_taken", {31'd0, d_if.pred_taken}, 32'd0);
        tick();
        check("idle_valid", {31'd0, d_if.pred_valid}, 32'd0);
        check("idle_index", {26'd0, d_if.pred_index}, 32'd4);

        // Saturation walk at index 4: 1 -> 3 -> 3 -> 2 -> 0 -> 0 -> 1
        d_upd(1'b1, 1'b0, 2);
        d_req("sat_after_2t", 1'b1);
        d_upd(1'b1, 1'b0, 1);
        d_upd(1'b0, 1'b0, 1);
        d_req("sat_top_then_1n", 1'b1);
        d_upd(1'b0, 1'b0, 2);
        d_req("sat_at_zero", 1'b0);
        d_upd(1'b0, 1'b0, 1);
        d_upd(1'b1, 1'b0, 1);
        d_req("sat_bottom_then_1t", 1'b0);

        // Same-cycle request and update at index 4 (counter 1): old value used
        d_if.req_valid = 1'b1;
        d_if.req_pc    = 32'h10;
        d_if.upd_valid = 1'b1;
        d_if.upd_index = 6'd4;
        d_if.upd_taken = 1'b1;
        d_if.upd_pred  = 1'b0;
        tick();
        d_if.req_valid = 1'b0;
        d_if.upd_valid = 1'b0;
        check("rbw_same_cycle", {31'd0, d_if.pred_taken}, 32'd0);
        d_req("rbw_next", 1'b1);

        // gshare history hashing
        g_upd(1'b1, 3);
        g_req("gs_ghr7_index", 6'd3);
        check("gs_ghr7_taken", {31'd0, g_if.pred_taken}, 32'd0);
        g_upd(1'b0, 1);
        g_req("gs_ghr14_index", 6'd10);
        g_if.req_valid = 1'b1;
        g_if.req_pc    = 32'h10;
        g_if.upd_valid = 1'b1;
        g_if.upd_index = 6'd0;
        g_if.upd_taken = 1'b1;
        tick();
        g_if.req_valid = 1'b0;
        g_if.upd_valid = 1'b0;
        check("gs_rbw_old_ghr", {26'd0, g_if.pred_index}, 32'd10);
        g_req("gs_ghr29_index", 6'd25);

        // 3-bit counters: init 3, taken after one taken update
        c_req("c3_init", 1'b0);
        c_if.upd_valid = 1'b1;
        c_if.upd_index = 6'd4;
        c_if.upd_taken = 1'b1;
        tick();
        c_if.upd_valid = 1'b0;
        c_req("c3_after_1t", 1'b1);

        // Train index 4 to 3, then reset mid-cycle
        d_upd(1'b1, 1'b0, 1);
        d_if.req_valid = 1'b1;
        d_if.req_pc    = 32'h10;
        tick();
        d_if.req_valid = 1'b0;
        check("pre_rst_taken", {31'd0, d_if.pred_taken}, 32'd1);
        check("pre_rst_stat_upd", {16'd0, d_if.stat_updates}, 32'd10);
        check("pre_rst_stat_mis", {16'd0, d_if.stat_mispredicts}, 32'd6);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, d_if.pred_valid}, 32'd0);
        check("mid_rst_taken", {31'd0, d_if.pred_taken}, 32'd0);
        check("mid_rst_index", {26'd0, d_if.pred_index}, 32'd0);
        check("mid_rst_stat_upd", {16'd0, d_if.stat_updates}, 32'd0);
        #2;
        reset = 1'b0;
        d_req("post_rst_taken", 1'b0);

        // Statistics: (pred,taken) = (1,0), (0,0), (0,1)
        d_upd(1'b0, 1'b1, 1);
        d_upd(1'b0, 1'b0, 1);
        d_upd(1'b1, 1'b0, 1);
        check("stat_upd_3", {16'd0, d_if.stat_updates}, 32'd3);
        check("stat_mis_2", {16'd0, d_if.stat_mispredicts}, 32'd2);
        d_upd(1'b0, 1'b1, 70000);
        check("stat_upd_sat", {16'd0, d_if.stat_updates}, 32'h0000FFFF);
        check("stat_mis_sat", {16'd0, d_if.stat_mispredicts}, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
Parametrised branch direction predictor: a table of 2^INDEX_BITS saturating counters, each CTR_BITS wide, replacing the single-counter predictor. It is indexed by PC in bimodal mode, or by PC XOR global history in gshare mode. It sits beside fetch: fetch issues a prediction request, and execute later returns the resolved outcome as an update. Two saturating performance counters track updates and mispredicts.

Parameters:
INDEX_BITS, 6, log2 of table depth (64 entries)
CTR_BITS, 2, width of each saturating counter (legal range 2..4)
HIST_BITS, 6, global history length; must be <= INDEX_BITS
MODE, 0, 0 = bimodal, 1 = gshare
PC_LSB, 2, lowest PC bit used for indexing

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  prediction request this cycle
req_pc  input  32  PC of the branch being predicted
pred_valid  output  1  prediction valid (registered)
pred_taken  output  1  predicted direction, 1 = taken
pred_index  output  INDEX_BITS  table index used; fetch carries it to the update
upd_valid  input  1  resolved-branch update this cycle
upd_index  input  INDEX_BITS  index returned from pred_index
upd_taken  input  1  actual outcome, 1 = taken
upd_pred  input  1  direction that was predicted for this branch
stat_updates  output  16  count of accepted updates, saturating
stat_mispredicts  output  16  count of updates with upd_pred != upd_taken, saturating

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - every table counter = 2^(CTR_BITS-1)-1 (weakly not-taken; value 1 for CTR_BITS=2)
  - GHR = 0
  - pred_valid = 0, pred_taken = 0, pred_index = 0
  - stat_updates = 0, stat_mispredicts = 0
  - The table is built from flops, not RAM, so that reset can clear it.
- Index computation (combinational, on the request):
  - base = req_pc[PC_LSB +: INDEX_BITS]
  - MODE=0: idx = base
  - MODE=1: idx = base XOR zero-extended GHR
- Prediction, latency 1 cycle:
  - On the edge where req_valid=1: pred_valid <= 1, pred_index <= idx, pred_taken <= MSB of table[idx].
  - On the edge where req_valid=0: pred_valid <= 0; pred_taken and pred_index hold their values.
  - One request per cycle; there is no backpressure.
- Update, takes effect on the edge where upd_valid=1:
  - upd_taken=1: table[upd_index] increments, saturating at 2^CTR_BITS-1.
  - upd_taken=0: table[upd_index] decrements, saturating at 0.
  - GHR <= {GHR[HIST_BITS-2:0], upd_taken}. The GHR is non-speculative: it changes only on updates, and it changes in both modes.
  - stat_updates increments, saturating at 0xFFFF.
  - If upd_pred != upd_taken, stat_mispredicts increments, saturating at 0xFFFF.
- Simultaneous request and update in the same cycle:
  - Read-before-write. The prediction uses the counter value and GHR as they were before that edge's update, including when idx == upd_index.
  - There is no bypass.
- Counter boundaries:
  - Taken at max stays at max; not-taken at 0 stays at 0.
  - The prediction is the counter MSB, so the threshold is 2^(CTR_BITS-1).
- Out-of-range values are impossible: every index is exactly INDEX_BITS wide.

Test Plan:
- Default parameters, reset released, req_pc=0x10 -> next cycle pred_valid=1, pred_index=4, pred_taken=0; the cycle after with req_valid=0 -> pred_valid=0, pred_index still 4.
- Counter saturation at idx 4:
  - 2 taken updates -> request 0x10 predicts 1.
  - 3rd taken update leaves the counter at 3.
  - 1 not-taken update -> still predicts 1.
  - 2 further not-taken updates -> counter 0, predicts 0.
  - 4th not-taken update -> counter remains 0.
- MODE=1: three taken updates (any index) -> GHR=0b000111; request 0x10 -> pred_index=3 (4 XOR 7). Then one not-taken update -> GHR=0b001110; request 0x10 -> pred_index=10.
- Same cycle, counter[4]=1: req_pc=0x10 together with upd_index=4, upd_taken=1 -> pred_taken=0. The next request to 0x10 -> pred_taken=1.
- Stat counters:
  - 3 updates with (upd_pred, upd_taken) = (1,0), (0,0), (0,1) -> stat_updates=3, stat_mispredicts=2.
  - 70000 mispredicting updates -> both counters read 0xFFFF.
- Mid-stream reset:
  - After the counter at idx 4 has been trained to 3, reset is asserted between clock edges.
  - Outputs go to 0 before the next clk edge.
  - After release, request 0x10 -> pred_taken=0.
  - CTR_BITS=3 variant: reset value 3; predicts taken only after 1 taken update (value 4).
